// File: rtl/approx_mul_pkg.sv
// Shared helpers and stage payload for the pipelined
// approximate unsigned multiplier.
package approx_mul_pkg;

  localparam int MAXW = 32;
  localparam int MAXT = 16;
  localparam int PW   = 2 * MAXW + 1;
  localparam int IW   = $clog2(MAXW);

  typedef struct packed {
    logic [2*MAXW-1:0] z;
    logic              exact;
    logic [MAXT-1:0]   tag;
  } stage_t;

  // Low l rows collapse to one OR per column near the row-l boundary,
  // plus a single compensation bit at column w-1.
  function automatic logic [PW-1:0] approx_pp(
    input logic [MAXW-1:0] x,
    input logic [MAXW-1:0] y,
    input int              w,
    input int              l
  );
    logic [PW-1:0]     acc;
    logic [PW-1:0]     lim;
    logic [2*MAXW-1:0] cols;
    logic              comp;
    int                c;
    int                k;
    acc  = '0;
    cols = '0;
    comp = 1'b0;
    for (int i = 0; i < MAXW; i++) begin
      if (i >= l && i < w && x[i[IW-1:0]])
        acc = acc + (PW'(y) << i);
      k = w - 2 - i;
      if (i < l && k >= 0)
        comp = comp | (x[i[IW-1:0]] & y[k[IW-1:0]]);
      for (int j = 0; j < MAXW; j++) begin
        c = i + j;
        if (i < l && j < w && c >= w - 1 && c <= w + l - 2)
          cols[c[IW:0]] = cols[c[IW:0]] |
                          (x[i[IW-1:0]] & y[j[IW-1:0]]);
      end
    end
    acc = acc + PW'(cols);
    acc = acc + (PW'(comp) << (w - 1));
    lim = (PW'(1) << (2 * w)) - PW'(1);
    if (acc > lim)
      acc = lim;
    return acc;
  endfunction

endpackage

// File: rtl/approx_umul_core.sv
// Combinational exact/approximate unsigned multiplier,
// usable standalone or inside the pipeline.
module approx_umul_core
  import approx_mul_pkg::*;
#(
  parameter int W = 8,
  parameter int L = 2
) (
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  input  logic           exact,
  output logic [2*W-1:0] z
);

  logic [PW-1:0]  ap;
  logic [2*W-1:0] ex;
  logic           unused_ap;

  assign ap = approx_pp(MAXW'(x), MAXW'(y), W, L);
  assign ex = (2 * W)'(x) * (2 * W)'(y);
  assign z  = exact ? ex : ap[2*W-1:0];

  // Upper bits are zero after saturation.
  assign unused_ap = ^ap;

endmodule

// File: rtl/approx_umul_pipe.sv
// Valid/ready pipeline around approx_umul_core; the whole
// pipe advances together and stalls freeze every stage.
module approx_umul_pipe
  import approx_mul_pkg::*;
#(
  parameter int W      = 8,
  parameter int L      = 2,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_x,
  input  logic [W-1:0]     in_y,
  input  logic             in_exact,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_z,
  output logic [TAG_W-1:0] out_tag
);

  logic              adv;
  logic [STAGES-1:0] v_q;
  logic [W-1:0]      x_q;
  logic [W-1:0]      y_q;
  logic              ex_q;
  logic [TAG_W-1:0]  tag_q;
  logic [2*W-1:0]    z_c;
  stage_t            s1;
  stage_t            out_s;
  logic              unused_s;

  assign adv       = !out_valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      x_q   <= '0;
      y_q   <= '0;
      ex_q  <= 1'b0;
      tag_q <= '0;
    end else if (adv) begin
      v_q <= (v_q << 1) | STAGES'(in_valid);
      if (in_valid) begin
        x_q   <= in_x;
        y_q   <= in_y;
        ex_q  <= in_exact;
        tag_q <= in_tag;
      end
    end
  end

  approx_umul_core #(
    .W(W),
    .L(L)
  ) u_core (
    .x    (x_q),
    .y    (y_q),
    .exact(ex_q),
    .z    (z_c)
  );

  always_comb begin
    s1       = '0;
    s1.z     = (2 * MAXW)'(z_c);
    s1.exact = ex_q;
    s1.tag   = MAXT'(tag_q);
  end

  if (STAGES == 1) begin : g_comb
    assign out_s = s1;
  end else begin : g_reg
    stage_t pay_q [STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < STAGES - 1; k++)
          pay_q[k] <= '0;
      end else if (adv) begin
        pay_q[0] <= s1;
        for (int k = 1; k < STAGES - 1; k++)
          pay_q[k] <= pay_q[k-1];
      end
    end

    assign out_s = pay_q[STAGES-2];
  end

  assign out_z    = out_s.z[2*W-1:0];
  assign out_tag  = out_s.tag[TAG_W-1:0];
  assign unused_s = ^out_s;

endmodule

// File: tb/tb_approx_umul_pipe.sv
// Self-checking bench for approx_umul_pipe: arithmetic model,
// scoreboard compare, directed vectors and a parameter sweep.
module tb_approx_umul_pipe;

  localparam int W = 8;
  localparam int L = 2;

  typedef struct {
    longint z;
    int     tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_x = '0;
  logic [7:0]  in_y = '0;
  logic        in_exact = 1'b0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_z;
  logic [3:0]  out_tag;

  logic [3:0]  a_x = '0, a_y = '0, a_tg = '0, a_to;
  logic        a_ex = 1'b0, a_v = 1'b0, a_ov, a_ir;
  logic [7:0]  a_z;
  logic [11:0] b_x = '0, b_y = '0;
  logic [3:0]  b_tg = '0, b_to;
  logic        b_ex = 1'b0, b_v = 1'b0, b_ov, b_ir;
  logic [23:0] b_z;
  logic [7:0]  c_x = '0, c_y = '0;
  logic [3:0]  c_tg = '0, c_to;
  logic        c_ex = 1'b0, c_v = 1'b0, c_ov, c_ir;
  logic [15:0] c_z;

  int     n_tests = 0;
  int     n_fail = 0;
  int     rdy_mode = 0;
  int     n_out = 0;
  longint last_z = 0;
  int     last_tag = 0;
  exp_t   q[$];
  exp_t   qa[$], qb[$], qc[$];

  approx_umul_pipe #(.W(8), .L(2), .STAGES(2), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .in_exact(in_exact), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_tag(out_tag));

  approx_umul_pipe #(.W(4), .L(1), .STAGES(1), .TAG_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_v), .in_ready(a_ir),
    .in_x(a_x), .in_y(a_y), .in_exact(a_ex), .in_tag(a_tg),
    .out_valid(a_ov), .out_ready(1'b1), .out_z(a_z),
    .out_tag(a_to));

  approx_umul_pipe #(.W(12), .L(3), .STAGES(3), .TAG_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_v), .in_ready(b_ir),
    .in_x(b_x), .in_y(b_y), .in_exact(b_ex), .in_tag(b_tg),
    .out_valid(b_ov), .out_ready(1'b1), .out_z(b_z),
    .out_tag(b_to));

  approx_umul_pipe #(.W(8), .L(0), .STAGES(3), .TAG_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_v), .in_ready(c_ir),
    .in_x(c_x), .in_y(c_y), .in_exact(c_ex), .in_tag(c_tg),
    .out_valid(c_ov), .out_ready(1'b1), .out_z(c_z),
    .out_tag(c_to));

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic void chk(string nm, longint got, longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endfunction

  function automatic longint model(int w, int l, longint x,
                                   longint y, bit ex);
    longint z;
    longint b;
    if (ex) return x * y;
    z = (y * (x >> l)) << l;
    for (int c = w - 1; c <= w + l - 2; c++) begin
      b = 0;
      for (int i = 0; i < l; i++)
        if (c - i < w) b = b | ((x >> i) & (y >> (c - i)) & 1);
      z = z + (b << c);
    end
    b = 0;
    for (int i = 0; i < l; i++)
      if (w - 2 - i >= 0)
        b = b | ((x >> i) & (y >> (w - 2 - i)) & 1);
    z = z + (b << (w - 1));
    if (z > (longint'(1) << (2 * w)) - 1)
      z = (longint'(1) << (2 * w)) - 1;
    return z;
  endfunction

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) out_ready = 1'b1;
    else out_ready = 1'($urandom_range(0, 1));
  end

  logic        held = 1'b0;
  logic [15:0] hz;
  logic [3:0]  ht;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold valid", longint'(out_valid), 1);
        chk("hold z", longint'(out_z), longint'(hz));
        chk("hold tag", longint'(out_tag), longint'(ht));
      end
      held = 1'b0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("extra output", 1, 0);
        end else begin
          e = q.pop_front();
          chk("z", longint'(out_z), e.z);
          chk("tag", longint'(out_tag), longint'(e.tag));
          last_z = longint'(out_z);
          last_tag = int'(out_tag);
          n_out++;
        end
      end else if (out_valid) begin
        held = 1'b1;
        hz = out_z;
        ht = out_tag;
      end
      if (in_valid && in_ready)
        q.push_back('{model(W, L, longint'(in_x), longint'(in_y),
                            in_exact), int'(in_tag)});
    end
  end

  task automatic send(input logic [7:0] x, input logic [7:0] y,
                      input logic ex, input logic [3:0] tg);
    int n;
    n = 0;
    in_x = x;
    in_y = y;
    in_exact = ex;
    in_tag = tg;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send bound", longint'(n), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain bound", longint'(n >= 2000), 0);
  endtask

  task automatic one(input logic [7:0] x, input logic [7:0] y,
                     input logic ex, input longint ez, string nm);
    send(x, y, ex, 4'd9);
    in_valid = 1'b0;
    drain();
    chk(nm, last_z, ez);
  endtask

  task automatic sweep_pop();
    exp_t e;
    if (a_ov) begin
      if (qa.size() == 0) chk("swA extra", 1, 0);
      else begin
        e = qa.pop_front();
        chk("swA z", longint'(a_z), e.z);
        chk("swA tag", longint'(a_to), longint'(e.tag));
      end
    end
    if (b_ov) begin
      if (qb.size() == 0) chk("swB extra", 1, 0);
      else begin
        e = qb.pop_front();
        chk("swB z", longint'(b_z), e.z);
        chk("swB tag", longint'(b_to), longint'(e.tag));
      end
    end
    if (c_ov) begin
      if (qc.size() == 0) chk("swC extra", 1, 0);
      else begin
        e = qc.pop_front();
        chk("swC z", longint'(c_z), e.z);
        chk("swC tag", longint'(c_to), longint'(e.tag));
      end
    end
  endtask

  initial begin
    int n0;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst out_valid", longint'(out_valid), 0);
    chk("rst out_z", longint'(out_z), 0);
    chk("rst out_tag", longint'(out_tag), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst in_ready", longint'(in_ready), 1);

    chk("model 255x255 ap", model(8, 2, 255, 255, 0), 64772);
    chk("model 255x255 ex", model(8, 2, 255, 255, 1), 65025);
    chk("model 3x64 ap", model(8, 2, 3, 64, 0), 256);
    chk("model 1x63 ap", model(8, 2, 1, 63, 0), 0);
    chk("model w4 l1", model(4, 1, 15, 15, 0), 226);
    chk("model l0", model(8, 0, 200, 177, 0), 35400);

    one(8'd255, 8'd255, 1'b0, 64772, "dir 255x255 ap");
    one(8'd255, 8'd255, 1'b1, 65025, "dir 255x255 ex");
    one(8'd3, 8'd128, 1'b0, 384, "dir 3x128 ap");
    one(8'd3, 8'd128, 1'b1, 384, "dir 3x128 ex");
    one(8'd3, 8'd64, 1'b0, 256, "dir 3x64 ap");
    one(8'd3, 8'd64, 1'b1, 192, "dir 3x64 ex");
    one(8'd1, 8'd63, 1'b0, 0, "dir 1x63 ap");
    one(8'd1, 8'd63, 1'b1, 63, "dir 1x63 ex");

    for (int k = 0; k < 16; k++) begin
      send(8'(k * 7 + 3), 8'(255 - k * 9), k[0], 4'(k));
      if (k == 0) chk("lat early", longint'(out_valid), 0);
      if (k == 1) begin
        chk("lat valid", longint'(out_valid), 1);
        chk("lat tag", longint'(out_tag), 0);
      end
    end
    chk("thru valid", longint'(out_valid), 1);
    chk("thru tag", longint'(out_tag), 14);
    in_valid = 1'b0;
    drain();

    rdy_mode = 1;
    n0 = n_out;
    for (int k = 0; k < 200; k++)
      send(8'($urandom), 8'($urandom), 1'($urandom), 4'(k));
    in_valid = 1'b0;
    drain();
    chk("random count", longint'(n_out - n0), 200);
    rdy_mode = 0;
    @(posedge clk);
    #1;

    send(8'd17, 8'd33, 1'b0, 4'd1);
    send(8'd99, 8'd201, 1'b1, 4'd2);
    chk("inflight valid", longint'(out_valid), 1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst valid", longint'(out_valid), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    n0 = n_out;
    send(8'd250, 8'd7, 1'b0, 4'd5);
    send(8'd128, 8'd255, 1'b0, 4'd6);
    in_valid = 1'b0;
    drain();
    chk("postrst count", longint'(n_out - n0), 2);
    chk("postrst tag", longint'(last_tag), 6);

    for (int k = 0; k < 64; k++) begin
      @(posedge clk);
      #1;
      a_v = (k < 60);
      b_v = (k < 60);
      c_v = (k < 60);
      a_x = 4'($urandom); a_y = 4'($urandom);
      a_ex = 1'($urandom); a_tg = 4'(k);
      b_x = 12'($urandom); b_y = 12'($urandom);
      b_ex = 1'($urandom); b_tg = 4'(k);
      c_x = 8'($urandom); c_y = 8'($urandom);
      c_ex = 1'($urandom); c_tg = 4'(k);
      @(negedge clk);
      sweep_pop();
      if (a_v) begin
        chk("swA ready", longint'(a_ir), 1);
        qa.push_back('{model(4, 1, longint'(a_x), longint'(a_y), a_ex),
                       k & 15});
      end
      if (b_v) begin
        chk("swB ready", longint'(b_ir), 1);
        qb.push_back('{model(12, 3, longint'(b_x), longint'(b_y), b_ex),
                       k & 15});
      end
      if (c_v) begin
        chk("swC ready", longint'(c_ir), 1);
        qc.push_back('{longint'(c_x) * longint'(c_y), k & 15});
      end
    end
    chk("swA left", longint'(qa.size()), 0);
    chk("swB left", longint'(qb.size()), 0);
    chk("swC left", longint'(qc.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
